// File: rtl/dmem_pkg.sv
// dmem_pkg: shared types and constants for the data-memory arbiter.
//   state_t          - sequencer states (IDLE, ACCESS, CAPTURE, RESP)
//   WORD_W, BYTE_W   - word and byte widths
//   MEM_LAST_DEFAULT - highest valid byte address of the data memory
//   addr_ok()        - alignment and range check for a word access
package dmem_pkg;

  localparam int WORD_W         = 32;
  localparam int BYTE_W         = 8;
  localparam int BYTES_PER_WORD = WORD_W / BYTE_W;

  localparam logic [WORD_W-1:0] MEM_LAST_DEFAULT = 32'd1000;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACCESS  = 2'd1,
    CAPTURE = 2'd2,
    RESP    = 2'd3
  } state_t;

  // The last byte of the word is computed one bit wider than the address so
  // an address near the top of the 32-bit space cannot wrap and pass.
  function automatic logic addr_ok(input logic [WORD_W-1:0] addr,
                                   input logic [WORD_W-1:0] last);
    logic [WORD_W:0] lastByte;
    lastByte = {1'b0, addr} + (WORD_W+1)'(BYTES_PER_WORD - 1);
    return (addr[1:0] == 2'b00) && (lastByte <= {1'b0, last});
  endfunction

endpackage

// File: rtl/dmem_arbiter_rr_arb2.sv
// rr_arb2: two-way round-robin picker, purely combinational.
//   req[1:0]  in   pending requests (bit 0 = requester 0)
//   lastGrant in   index granted most recently
//   grant     out  one-hot grant, zero when nothing is requested
//   grantIdx  out  index of the granted requester
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       lastGrant,
  output logic [1:0] grant,
  output logic       grantIdx
);

  always_comb begin
    grantIdx = 1'b0;
    grant    = 2'b00;
    if (req == 2'b11) begin
      // Tie: the requester that did not win last time goes first.
      grantIdx = ~lastGrant;
    end else if (req == 2'b10) begin
      grantIdx = 1'b1;
    end
    if (req != 2'b00) begin
      grant = grantIdx ? 2'b10 : 2'b01;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: round-robin arbiter and access sequencer for the byte-addressed,
// big-endian data memory. Checks alignment/range before any access and drives
// single-cycle memory strobes.
//   clk, rst                    clock, async active-high reset
//   r0*/r1*  Req,We,Addr,WData  requests (held until ack/err)
//   r0*/r1*  Ack,Err,RData      one-cycle responses, read data
//   memRead, memWrite           single-cycle strobes (only in ACCESS)
//   memAddress, memWriteData    latched access address / write data
//   memReadData                 memory read data
//
// state   | meaning
// IDLE    | arbitrate, latch request, check address
// ACCESS  | one-cycle read or write strobe
// CAPTURE | register memory read data
// RESP    | ack or err pulse to the granted requester
import dmem_pkg::*;

module dmem_arbiter #(
  parameter logic [WORD_W-1:0] MEM_LAST = MEM_LAST_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              r0Req,
  input  logic              r0We,
  input  logic [WORD_W-1:0] r0Addr,
  input  logic [WORD_W-1:0] r0WData,
  output logic              r0Ack,
  output logic              r0Err,
  output logic [WORD_W-1:0] r0RData,
  input  logic              r1Req,
  input  logic              r1We,
  input  logic [WORD_W-1:0] r1Addr,
  input  logic [WORD_W-1:0] r1WData,
  output logic              r1Ack,
  output logic              r1Err,
  output logic [WORD_W-1:0] r1RData,
  output logic              memRead,
  output logic              memWrite,
  output logic [WORD_W-1:0] memAddress,
  output logic [WORD_W-1:0] memWriteData,
  input  logic [WORD_W-1:0] memReadData
);

  state_t            state, stateNext;
  logic              lastGrant;
  logic              gntIdx;
  logic              weReg;
  logic              errReg;
  logic [WORD_W-1:0] rdataReg;

  logic [1:0]        arbGrant;
  logic              arbIdx;
  logic [WORD_W-1:0] selAddr;
  logic              addrGood;
  logic              take;

  rr_arb2 u_arb (
    .req      ({r1Req, r0Req}),
    .lastGrant(lastGrant),
    .grant    (arbGrant),
    .grantIdx (arbIdx)
  );

  assign selAddr  = arbIdx ? r1Addr : r0Addr;
  assign addrGood = addr_ok(selAddr, MEM_LAST);
  assign take     = (state == IDLE) && (arbGrant != 2'b00);

  always_comb begin
    stateNext = state;
    memRead   = 1'b0;
    memWrite  = 1'b0;
    r0Ack     = 1'b0;
    r1Ack     = 1'b0;
    r0Err     = 1'b0;
    r1Err     = 1'b0;
    case (state)
      IDLE: begin
        if (take) stateNext = addrGood ? ACCESS : RESP;
      end
      ACCESS: begin
        stateNext = weReg ? RESP : CAPTURE;
        // Gated by rst so a write aborted before its edge never commits.
        memWrite  = weReg & ~rst;
        memRead   = ~weReg & ~rst;
      end
      CAPTURE: stateNext = RESP;
      RESP: begin
        stateNext = IDLE;
        r0Ack     = ~errReg & ~gntIdx;
        r1Ack     = ~errReg &  gntIdx;
        r0Err     =  errReg & ~gntIdx;
        r1Err     =  errReg &  gntIdx;
      end
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      lastGrant    <= 1'b1;
      gntIdx       <= 1'b0;
      weReg        <= 1'b0;
      errReg       <= 1'b0;
      memAddress   <= '0;
      memWriteData <= '0;
      rdataReg     <= '0;
      r0RData      <= '0;
      r1RData      <= '0;
    end else begin
      state <= stateNext;
      if (take) begin
        lastGrant    <= arbIdx;
        gntIdx       <= arbIdx;
        weReg        <= arbIdx ? r1We : r0We;
        errReg       <= ~addrGood;
        memAddress   <= selAddr;
        memWriteData <= arbIdx ? r1WData : r0WData;
      end
      // Only the granted port's read data register moves; the other holds.
      if (state == CAPTURE) begin
        rdataReg <= memReadData;
        if (gntIdx) r1RData <= memReadData;
        else        r0RData <= memReadData;
      end
    end
  end

  // A granted requester must keep Req high until its response has been seen.
  always_ff @(posedge clk) begin
    if (!rst && state != IDLE) begin
      assert (gntIdx ? r1Req : r0Req)
        else $error("dmem_arbiter: granted request dropped before response");
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
module tb_dmem_arbiter;
  import dmem_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        r0Req, r1Req, r0We, r1We;
  logic [31:0] r0Addr, r1Addr, r0WData, r1WData;
  logic        r0Ack, r1Ack, r0Err, r1Err;
  logic [31:0] r0RData, r1RData;
  logic        memRead, memWrite;
  logic [31:0] memAddress, memWriteData, memReadData;
  logic        memInit;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int strobeCnt = 0;
  int bothCnt = 0;

  typedef struct {
    int          port;
    bit          isErr;
    bit          isRead;
    logic [31:0] data;
    int          due;
  } exp_t;
  exp_t sb[$];

  logic [7:0] mem [0:1023];
  logic [9:0] ma;
  assign ma = memAddress[9:0];

  always #5 clk = ~clk;

  dmem_arbiter dut (
    .clk(clk), .rst(rst),
    .r0Req(r0Req), .r0We(r0We), .r0Addr(r0Addr), .r0WData(r0WData),
    .r0Ack(r0Ack), .r0Err(r0Err), .r0RData(r0RData),
    .r1Req(r1Req), .r1We(r1We), .r1Addr(r1Addr), .r1WData(r1WData),
    .r1Ack(r1Ack), .r1Err(r1Err), .r1RData(r1RData),
    .memRead(memRead), .memWrite(memWrite),
    .memAddress(memAddress), .memWriteData(memWriteData),
    .memReadData(memReadData)
  );

  // Big-endian byte memory model plus strobe monitors.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (memRead || memWrite) strobeCnt <= strobeCnt + 1;
    if (memRead && memWrite) bothCnt <= bothCnt + 1;
    if (memInit) begin
      for (int i = 0; i < 1024; i++) mem[i] <= 8'h00;
    end else if (memWrite) begin
      mem[ma]         <= memWriteData[31:24];
      mem[ma + 10'd1] <= memWriteData[23:16];
      mem[ma + 10'd2] <= memWriteData[15:8];
      mem[ma + 10'd3] <= memWriteData[7:0];
    end
    if (memRead) memReadData <= {mem[ma], mem[ma + 10'd1], mem[ma + 10'd2], mem[ma + 10'd3]};
  end

  function automatic logic [31:0] memWord(input int a);
    return {mem[a], mem[a+1], mem[a+2], mem[a+3]};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic raise(input int port, input bit we, input logic [31:0] addr, input logic [31:0] wd);
    if (port == 0) begin
      r0Req = 1'b1; r0We = we; r0Addr = addr; r0WData = wd;
    end else begin
      r1Req = 1'b1; r1We = we; r1Addr = addr; r1WData = wd;
    end
  endtask

  task automatic drop(input int port);
    if (port == 0) r0Req = 1'b0;
    else           r1Req = 1'b0;
  endtask

  task automatic expect_resp(input int port, input bit isErr, input bit isRead,
                             input logic [31:0] data, input int lat);
    exp_t e;
    e.port = port; e.isErr = isErr; e.isRead = isRead; e.data = data; e.due = cyc + lat;
    sb.push_back(e);
  endtask

  // Waits for n responses, scoring each against the queue head. The responding
  // port's Req is dropped just after the edge that ends RESP, unless holdFirst.
  task automatic collect(input int n, input bit holdFirst);
    int          got;
    int          budget;
    int          port;
    bit          hold;
    logic [31:0] nresp;
    logic [31:0] rd;
    exp_t        e;
    got = 0; budget = 0; hold = holdFirst;
    while (got < n && budget < 40) begin
      @(negedge clk);
      budget++;
      if (r0Ack || r0Err || r1Ack || r1Err) begin
        nresp = 32'(r0Ack) + 32'(r0Err) + 32'(r1Ack) + 32'(r1Err);
        chk("single_resp", nresp, 32'd1);
        port = (r1Ack || r1Err) ? 1 : 0;
        rd   = port ? r1RData : r0RData;
        chk("sb_pending", 32'(sb.size() > 0), 32'd1);
        if (sb.size() > 0) begin
          e = sb.pop_front();
          chk("resp_port", 32'(port), 32'(e.port));
          chk("resp_err", 32'(r0Err || r1Err), 32'(e.isErr));
          chk("resp_cycle", 32'(cyc), 32'(e.due));
          if (e.isRead && !e.isErr) chk("resp_rdata", rd, e.data);
        end
        got++;
        @(posedge clk);
        #1;
        if (hold) hold = 1'b0;
        else      drop(port);
      end
    end
    chk("resp_count", 32'(got), 32'(n));
  endtask

  initial begin
    int s0;
    int ackSeen;
    rst = 1'b1; memInit = 1'b1;
    r0Req = 1'b0; r0We = 1'b0; r0Addr = '0; r0WData = '0;
    r1Req = 1'b0; r1We = 1'b0; r1Addr = '0; r1WData = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0; memInit = 1'b0;

    // Reset values
    @(negedge clk);
    chk("rst_acks", {28'b0, r0Ack, r1Ack, r0Err, r1Err}, 32'd0);
    chk("rst_strobes", {30'b0, memRead, memWrite}, 32'd0);
    chk("rst_memAddress", memAddress, 32'd0);
    chk("rst_memWriteData", memWriteData, 32'd0);
    chk("rst_r0RData", r0RData, 32'd0);
    chk("rst_r1RData", r1RData, 32'd0);
    chk("rst_lastGrant", 32'(dut.lastGrant), 32'd1);

    // Single write then read at address 0
    raise(0, 1'b1, 32'd0, 32'h077FDFF0);
    expect_resp(0, 1'b0, 1'b0, 32'h0, 2);
    collect(1, 1'b0);
    chk("mem_b0", {24'b0, mem[0]}, 32'h07);
    chk("mem_b1", {24'b0, mem[1]}, 32'h7F);
    chk("mem_b2", {24'b0, mem[2]}, 32'hDF);
    chk("mem_b3", {24'b0, mem[3]}, 32'hF0);
    @(negedge clk);
    raise(0, 1'b0, 32'd0, 32'h0);
    expect_resp(0, 1'b0, 1'b1, 32'h077FDFF0, 3);
    collect(1, 1'b0);

    // r1 alone writes address 4
    @(negedge clk);
    raise(1, 1'b1, 32'd4, 32'hA5A51234);
    expect_resp(1, 1'b0, 1'b0, 32'h0, 2);
    collect(1, 1'b0);
    chk("mem_w4", memWord(4), 32'hA5A51234);

    // Tie after r1 won: r0 then r1 (reads)
    @(negedge clk);
    raise(0, 1'b0, 32'd0, 32'h0);
    raise(1, 1'b0, 32'd4, 32'h0);
    expect_resp(0, 1'b0, 1'b1, 32'h077FDFF0, 3);
    expect_resp(1, 1'b0, 1'b1, 32'hA5A51234, 7);
    collect(2, 1'b0);
    chk("r0_rdata_hold", r0RData, 32'h077FDFF0);

    // Tie again: r0 then r1 (writes)
    @(negedge clk);
    raise(0, 1'b1, 32'd8, 32'h11223344);
    raise(1, 1'b1, 32'd12, 32'h55667788);
    expect_resp(0, 1'b0, 1'b0, 32'h0, 2);
    expect_resp(1, 1'b0, 1'b0, 32'h0, 5);
    collect(2, 1'b0);
    chk("mem_w8", memWord(8), 32'h11223344);
    chk("mem_w12", memWord(12), 32'h55667788);

    // r0 alone, then a tie: r1 must win now
    @(negedge clk);
    raise(0, 1'b0, 32'd8, 32'h0);
    expect_resp(0, 1'b0, 1'b1, 32'h11223344, 3);
    collect(1, 1'b0);
    @(negedge clk);
    raise(0, 1'b0, 32'd12, 32'h0);
    raise(1, 1'b0, 32'd8, 32'h0);
    expect_resp(1, 1'b0, 1'b1, 32'h11223344, 3);
    expect_resp(0, 1'b0, 1'b1, 32'h55667788, 7);
    collect(2, 1'b0);

    // Misaligned and out-of-range accesses
    s0 = strobeCnt;
    @(negedge clk);
    raise(1, 1'b0, 32'd2, 32'h0);
    expect_resp(1, 1'b1, 1'b0, 32'h0, 1);
    collect(1, 1'b0);
    @(negedge clk);
    raise(0, 1'b1, 32'd998, 32'hBAD0BAD0);
    expect_resp(0, 1'b1, 1'b0, 32'h0, 1);
    collect(1, 1'b0);
    @(negedge clk);
    raise(0, 1'b1, 32'd1000, 32'hBAD1BAD1);
    expect_resp(0, 1'b1, 1'b0, 32'h0, 1);
    collect(1, 1'b0);
    @(negedge clk);
    raise(1, 1'b0, 32'hFFFFFFFC, 32'h0);
    expect_resp(1, 1'b1, 1'b0, 32'h0, 1);
    collect(1, 1'b0);
    chk("err_no_strobe", 32'(strobeCnt - s0), 32'd0);
    chk("err_mem996", memWord(996), 32'h0);
    chk("err_mem1000", memWord(1000), 32'h0);
    chk("err_mem0", memWord(0), 32'h077FDFF0);

    // Highest valid word
    @(negedge clk);
    raise(0, 1'b1, 32'd996, 32'hDEADBEEF);
    expect_resp(0, 1'b0, 1'b0, 32'h0, 2);
    collect(1, 1'b0);
    @(negedge clk);
    raise(1, 1'b0, 32'd996, 32'h0);
    expect_resp(1, 1'b0, 1'b1, 32'hDEADBEEF, 3);
    collect(1, 1'b0);

    // Reset during ACCESS of a write
    @(negedge clk);
    raise(0, 1'b1, 32'd100, 32'hCAFEF00D);
    @(posedge clk);
    #2;
    chk("pre_rst_memWrite", 32'(memWrite), 32'd1);
    rst = 1'b1;
    #1;
    chk("rst_memWrite_drop", 32'(memWrite), 32'd0);
    chk("rst_memRead_low", 32'(memRead), 32'd0);
    r0Req = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    ackSeen = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (r0Ack || r1Ack || r0Err || r1Err) ackSeen++;
    end
    chk("rst_no_ack", 32'(ackSeen), 32'd0);
    chk("rst_mem_unchanged", memWord(100), 32'h0);
    chk("rst_state_idle", 32'(dut.state), 32'(IDLE));
    chk("rst_lastGrant_again", 32'(dut.lastGrant), 32'd1);

    // Back-to-back: r0 holds Req one cycle past ack
    @(negedge clk);
    raise(0, 1'b0, 32'd0, 32'h0);
    expect_resp(0, 1'b0, 1'b1, 32'h077FDFF0, 3);
    expect_resp(0, 1'b0, 1'b1, 32'h077FDFF0, 7);
    $display("NOTE protocol: r0 holds Req past ack; a second identical read is expected");
    collect(2, 1'b1);

    @(negedge clk);
    chk("never_both_strobes", 32'(bothCnt), 32'd0);
    chk("sb_drained", 32'(sb.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-requester arbiter and access sequencer for the byte-addressed, big-endian data memory. It arbitrates between requester 0 (CPU load/store stage) and requester 1 (program loader / debug port) with round-robin priority. It drives the memory's single-cycle strobes and checks alignment and range before any access, returning one-cycle ack/err responses. It sits between the pipeline's MEM stage and the data memory.

## Interface
- MEM_LAST, 1000: highest valid byte address in the data memory.
- clk  in  1  system clock; all state changes on posedge.
- rst  in  1  asynchronous, active-high reset.
- r0Req / r1Req  in  1  request, held until ack/err.
- r0We / r1We  in  1  1 = write word, 0 = read word.
- r0Addr / r1Addr  in  32  byte address.
- r0WData / r1WData  in  32  write data, big-endian byte order.
- r0Ack / r1Ack  out  1  one-cycle completion pulse.
- r0Err / r1Err  out  1  one-cycle error pulse, exclusive with ack.
- r0RData / r1RData  out  32  read data, valid while the matching ack is high.
- memRead  out  1  memory read strobe.
- memWrite  out  1  memory write strobe.
- memAddress  out  32  latched byte address.
- memWriteData  out  32  latched write data.
- memReadData  in  32  memory read data, updated at the posedge that samples memRead.

## Operation
- FSM states: IDLE, ACCESS, CAPTURE, RESP.
- IDLE
  - Arbitrate among asserted requests.
  - Latch the grant index, address, we and wdata.
  - Check the address: it must satisfy addr[1:0] == 0 and addr + 3 <= MEM_LAST, computed at 33 bits so it cannot wrap.
  - Check fails -> RESP with err set. Check passes -> ACCESS.
  - No request -> stay in IDLE.
- ACCESS
  - Assert memRead (read) or memWrite (write) for exactly this cycle.
  - Read -> CAPTURE. Write -> RESP.
- CAPTURE: register memReadData into rdataReg, then go to RESP.
- RESP
  - Pulse ack (or err) for the granted requester only, then return to IDLE.
  - RData for the granted port = rdataReg. The other port's RData holds its last value.
- Arbitration
  - lastGrant register; on simultaneous requests, grant the port != lastGrant.
  - lastGrant updates on every grant, error grants included.
  - A single request is granted regardless of lastGrant.
- Strobes are never both high. Outside ACCESS both are 0.
- Requester rules
  - Addr, We and WData must stay stable while Req is high.
  - The requester must drop Req the cycle after ack/err. Req still high in IDLE counts as a new request.
  - A request dropped before ack is undefined behaviour. It is asserted against in simulation.

## Timing
- Reset values: state = IDLE, lastGrant = 1 (r0 wins the first tie), memRead = memWrite = 0, memAddress = memWriteData = 0, rdataReg = 0, all acks/errs 0, RData 0.
- Read latency: request sampled at edge k; ACCESS in cycle k+1; CAPTURE in k+2; ack in k+3.
- Write latency: ACCESS in k+1; ack in k+2. The memory commits the write at the edge ending ACCESS.
- Error latency: err in k+1. No strobe is asserted.
- Throughput: one access per 3 (write) or 4 (read) cycles. A request arriving during a busy cycle waits; there is no queueing beyond Req hold.
- rst asserted mid-operation
  - Strobes drop combinationally and the FSM returns to IDLE.
  - A write whose ACCESS edge has not occurred is not performed.
  - No ack is issued for the aborted transaction.

## Structure
- Shared package dmem_pkg:
  - state enum (IDLE, ACCESS, CAPTURE, RESP).
  - MEM_LAST default constant.
  - Word/byte width constants.
- Sub-module rr_arb2: 2-way round-robin picker (req[1:0], lastGrant -> grant, grantIdx). Purely combinational, instantiated once.
- Everything else lives in dmem_arbiter. The memory is external.

## Test plan
- Single write then read
  - Stimulus: r0 writes 0x077FDFF0 to address 0, then reads address 0.
  - Response: write ack at k+2; read ack at k+3 with r0RData = 0x077FDFF0; memory bytes 0..3 = 07,7F,DF,F0.
- Simultaneous requests after reset
  - Stimulus: r0 and r1 both request.
  - Response: r0 is served first, then r1. Two further simultaneous rounds alternate r0, r1.
- Misaligned and out-of-range addresses
  - Stimulus: r1 reads address 0x2; r0 writes address 998 (998 + 3 > 1000).
  - Response: err pulses one cycle after each request, memRead/memWrite stay 0, memory is unchanged.
- Highest valid word
  - Stimulus: write then read address 996.
  - Response: succeeds; readback matches.
- Reset during ACCESS of a write
  - Stimulus: rst asserted in ACCESS before the edge.
  - Response: memWrite falls immediately, memory is unchanged, no ack, FSM is in IDLE with lastGrant = 1.
- Back-to-back requests
  - Stimulus: r0 holds Req one cycle past ack.
  - Response: a second identical transaction is issued. Flag a protocol note in the bench.
